des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Generates the sixteen 48-bit DES round subkeys from a 64-bit key, one subkey per accepted handshake.
- Sits directly upstream of the round datapath and drives its key_dat input in lockstep with the round counter.
- Applies PC-1 once at load, performs per-round C/D rotations in registers, and applies PC-2 combinationally to the registered C/D state.

Parameters:
- ROUNDS, 16, number of subkeys issued per schedule; legal range 1..16; values below 16 give a reduced-round test schedule.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load key_in and begin a schedule; honoured only in IDLE
- key_in  input  64  DES key; DES bit 1 = key_in[63]; parity bits (8,16,..,64) ignored
- key_ready  input  1  consumer accepts the current subkey
- round_key  output  48  current subkey Kn; DES bit 1 = round_key[47]
- key_valid  output  1  round_key is valid
- round_idx  output  4  index of the presented subkey, 0..ROUNDS-1
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the last subkey is accepted

Behaviour:
- Reset values (async, rst_n low): state=IDLE, C=D=0, round_idx=0, key_valid=0, busy=0, done=0. round_key is then PC-2 of zero, which is 0.
- SHIFT table, index 0..15: {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
- IDLE:
  - On start, register C,D <= rotl(PC1(key_in), SHIFT[0]) on each 28-bit half independently, set round_idx=0, go to RUN.
  - Latency: start at cycle T gives key_valid=1 with K1 at cycle T+1.
- RUN:
  - key_valid=1, busy=1, round_key=PC2({C,D}) (combinational from registers).
  - Transfer occurs on key_valid && key_ready.
  - Transfer with round_idx < ROUNDS-1: C,D <= rotl(C,D, SHIFT[round_idx+1]) and round_idx++.
  - Transfer with round_idx == ROUNDS-1: go to DONE.
  - key_ready low: all state holds and round_key stays stable (stall).
- DONE: one cycle with done=1, key_valid=0, busy=0; then IDLE. round_idx returns to 0 on DONE→IDLE.
- start outside IDLE (RUN or DONE) is ignored. key_in is sampled only in the start cycle; later changes have no effect.
- start and the final transfer in the same cycle: start is ignored because state is RUN, not IDLE.
- rst_n asserted mid-schedule: immediate return to reset values and the schedule is abandoned; a new start is required.
- ROUNDS outside 1..16 is a compile-time error (generate-time check).

Optional Feature:
- Macro: DES_KEY_DECRYPT_EN. It adds input port decrypt (1 bit), sampled with start.
- Defined, with decrypt=1:
  - Load C,D <= PC1(key_in) unrotated (equal to C16/D16), giving K16 first.
  - After a transfer at round_idx n (n < ROUNDS-1): C,D <= rotr(C,D, SHIFT[15-n]).
  - round_idx still counts 0 upward; the subkeys come out in order K16..K1.
  - With decrypt=1, ROUNDS must be 16; the generate check enforces this.
- Defined, with decrypt=0: identical to encrypt behaviour.
- Undefined: the port is absent and the block is encrypt-only.

Decomposition:
- Package des_pkg: SHIFT table constant, PC-1 (56 entries) and PC-2 (48 entries) index tables, and a state enum {IDLE, RUN, DONE}.
- One natural sub-module, des_pc2: purely combinational 56→48 permutation, reusable by other key paths.
- PC-1 and the rotations stay inline.

Test Plan:
- Encrypt schedule: key 0x133457799BBCDFF1, start, key_ready held 1 → cycle T+1 round_key=0x1B02EFFC7072 with idx 0; cycle T+2 0x79AED9DBC9E5; idx 15 gives 0xCB3D8B0E17F5; done pulse at T+17.
- Backpressure: same key, key_ready=0 for 5 cycles at idx 1 → round_key held at 0x79AED9DBC9E5 and idx=1 throughout; resumes correctly when key_ready returns to 1.
- Ignored start: assert start with a different key at idx 7 → sequence unchanged, all 16 keys still match 0x133457799BBCDFF1.
- Reset mid-run: deassert rst_n at idx 9 → key_valid=0, busy=0, idx=0 immediately; a new start reproduces K1=0x1B02EFFC7072.
- DES_KEY_DECRYPT_EN with decrypt=1, same key → idx 0 gives 0xCB3D8B0E17F5, idx 14 gives 0x79AED9DBC9E5, idx 15 gives 0x1B02EFFC7072.
- Weak key 0x0101010101010101 → all 16 subkeys are 0x000000000000; done asserted exactly once.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// Shared DES key-schedule tables and helpers: SHIFT, PC-1, PC-2, rotations and FSM states.
// Table entries are DES bit numbers (1 = MSB), exactly as printed in FIPS 46-3.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } des_state_e;

    localparam logic [1:0] SHIFT [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES bit n of a W-bit vector lives at index W-n.
    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[55-j] = key[64-PC1_TAB[j]];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Bundle between the key schedule and its producer/consumer.
// Optional decrypt input exists only when DES_KEY_DECRYPT_EN is defined.
interface des_key_schedule_if;
    import des_pkg::*;

    // start is accepted only while idle. A subkey transfers on any rising edge with
    // key_valid && key_ready; while key_ready is low, round_key/round_idx hold steady.
    logic        start;
    logic [63:0] key_in;
    logic        key_ready;
`ifdef DES_KEY_DECRYPT_EN
    logic        decrypt;
`endif
    logic [47:0] round_key;
    logic        key_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    des_state_e  state_dbg;

    modport master (
`ifdef DES_KEY_DECRYPT_EN
        output decrypt,
`endif
        output start, key_in, key_ready,
        input  round_key, key_valid, round_idx, busy, done, state_dbg
    );

    modport slave (
`ifdef DES_KEY_DECRYPT_EN
        input  decrypt,
`endif
        input  start, key_in, key_ready,
        output round_key, key_valid, round_idx, busy, done, state_dbg
    );

endinterface

// File: rtl/des_key_schedule_pc2.sv
// DES Permuted Choice 2: combinational 56-bit {C,D} to 48-bit subkey selection.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] key_o
);

    always_comb begin
        key_o = '0;
        for (int j = 0; j < 48; j++) begin
            key_o[47-j] = cd_i[56-PC2_TAB[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1 at load, C/D rotations per transfer, PC-2 on the registered state.
// Define DES_KEY_DECRYPT_EN to add the decrypt input, which issues K16..K1 instead of K1..K16.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    des_key_schedule_if.slave ks
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    generate
        if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
            $error("des_key_schedule: ROUNDS must be in 1..16");
        end
`ifdef DES_KEY_DECRYPT_EN
        if (ROUNDS != 16) begin : g_bad_decrypt_rounds
            $error("des_key_schedule: decrypt support requires ROUNDS == 16");
        end
`endif
    endgenerate

    des_state_e  state_q, state_d;
    logic [27:0] c_half_q, c_half_d;
    logic [27:0] d_half_q, d_half_d;
    logic [3:0]  idx_q, idx_d;
    logic [55:0] pc1_key;
    logic [47:0] round_key;
`ifdef DES_KEY_DECRYPT_EN
    logic        dec_q, dec_d;
`endif

    assign pc1_key = pc1_perm(ks.key_in);

    always_comb begin
        state_d  = state_q;
        c_half_d = c_half_q;
        d_half_d = d_half_q;
        idx_d    = idx_q;
`ifdef DES_KEY_DECRYPT_EN
        dec_d    = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    c_half_d = rotl28(pc1_key[55:28], SHIFT[0]);
                    d_half_d = rotl28(pc1_key[27:0], SHIFT[0]);
`ifdef DES_KEY_DECRYPT_EN
                    dec_d = ks.decrypt;
                    // C16/D16 equal the unrotated PC-1 halves (total rotation is 28).
                    if (ks.decrypt) begin
                        c_half_d = pc1_key[55:28];
                        d_half_d = pc1_key[27:0];
                    end
`endif
                    idx_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ks.key_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        c_half_d = rotl28(c_half_q, SHIFT[idx_q + 4'd1]);
                        d_half_d = rotl28(d_half_q, SHIFT[idx_q + 4'd1]);
`ifdef DES_KEY_DECRYPT_EN
                        if (dec_q) begin
                            c_half_d = rotr28(c_half_q, SHIFT[4'd15 - idx_q]);
                            d_half_d = rotr28(d_half_q, SHIFT[4'd15 - idx_q]);
                        end
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_half_q <= '0;
            d_half_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            c_half_q <= c_half_d;
            d_half_q <= d_half_d;
            idx_q    <= idx_d;
        end
    end

`ifdef DES_KEY_DECRYPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    des_pc2 u_pc2 (
        .cd_i  ({c_half_q, d_half_q}),
        .key_o (round_key)
    );

    assign ks.round_key = round_key;
    assign ks.key_valid = (state_q == RUN);
    assign ks.busy      = (state_q == RUN);
    assign ks.done      = (state_q == DONE);
    assign ks.round_idx = idx_q;
    assign ks.state_dbg = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: a driver queues {idx, subkey} expectations,
// a negedge monitor compares every presented subkey against the queue head.
module tb_des_key_schedule;
    import des_pkg::*;

    localparam logic [63:0] KEY_MAIN  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_OTHER = 64'hFEDCBA9876543210;
    localparam logic [63:0] KEY_WEAK  = 64'h0101010101010101;

    // K1..K16 for KEY_MAIN, hand-derived from the classic worked DES example.
    localparam logic [47:0] ENC_K [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    int   done_cnt;
    int   done_base;

    logic [51:0] exp_q[$];

    des_key_schedule_if ks ();

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [51:0] head;
        if (ks.done === 1'b1) done_cnt++;
        if (rst_n && ks.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_key: got idx %0d key %h, expected nothing (t=%0t)",
                         ks.round_idx, ks.round_key, $time);
            end else begin
                head = exp_q[0];
                check("round_key", {16'h0, ks.round_key}, {16'h0, head[47:0]});
                check("round_idx", {60'h0, ks.round_idx}, {60'h0, head[51:48]});
                if (ks.key_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_enc();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), ENC_K[i]});
    endtask

    task automatic push_dec();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), ENC_K[15-i]});
    endtask

    task automatic push_zero();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 48'h0});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the start edge, when K-first must already be valid.
    task automatic start_sched(input logic [63:0] key);
        @(posedge clk);
        #1;
        ks.start  = 1'b1;
        ks.key_in = key;
        @(posedge clk);
        #1;
        ks.start  = 1'b0;
        ks.key_in = ~key;
        check("latency_valid", {63'h0, ks.key_valid}, 64'h1);
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk);
            #1;
            if (ks.done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {63'h0, seen}, 64'h1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {63'h0, ks.key_valid}, 64'h0);
        check({tag, "_busy"},  {63'h0, ks.busy},      64'h0);
        check({tag, "_done"},  {63'h0, ks.done},      64'h0);
        check({tag, "_idx"},   {60'h0, ks.round_idx}, 64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec     = 0;
        n_miss    = 0;
        done_cnt  = 0;
        done_base = 0;
        rst_n        = 1'b0;
        ks.start     = 1'b0;
        ks.key_in    = '0;
        ks.key_ready = 1'b1;
`ifdef DES_KEY_DECRYPT_EN
        ks.decrypt   = 1'b0;
`endif

        // Reset values
        idle(2);
        check_idle_outputs("reset");
        check("reset_round_key", {16'h0, ks.round_key}, 64'h0);
        check("reset_state", {62'h0, ks.state_dbg}, {62'h0, IDLE});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 1: encrypt schedule with key_ready held high, exact done timing
        push_enc();
        start_sched(KEY_MAIN);
        check("busy_in_run", {63'h0, ks.busy}, 64'h1);
        idle(15);
        check("last_idx", {60'h0, ks.round_idx}, 64'd15);
        check("no_early_done", {63'h0, ks.done}, 64'h0);
        idle(1);
        check("done_at_T17", {63'h0, ks.done}, 64'h1);
        check("done_valid_low", {63'h0, ks.key_valid}, 64'h0);
        check("done_busy_low", {63'h0, ks.busy}, 64'h0);
        idle(1);
        check_idle_outputs("after_done");
        idle(2);

        // 2: backpressure at idx 1 for five cycles
        push_enc();
        start_sched(KEY_MAIN);
        idle(1);
        ks.key_ready = 1'b0;
        idle(5);
        check("stall_idx", {60'h0, ks.round_idx}, 64'd1);
        check("stall_key", {16'h0, ks.round_key}, {16'h0, ENC_K[1]});
        ks.key_ready = 1'b1;
        wait_done(40);
        idle(2);

        // 3: start ignored during RUN, on the final transfer, and in DONE
        push_enc();
        start_sched(KEY_MAIN);
        idle(7);
        ks.start  = 1'b1;
        ks.key_in = KEY_OTHER;
        idle(1);
        ks.start  = 1'b0;
        idle(7);
        check("pre_final_idx", {60'h0, ks.round_idx}, 64'd15);
        ks.start  = 1'b1;
        ks.key_in = KEY_OTHER;
        idle(1);
        check("final_xfer_done", {63'h0, ks.done}, 64'h1);
        idle(1);
        ks.start = 1'b0;
        check("start_in_done_ignored", {63'h0, ks.key_valid}, 64'h0);
        idle(3);
        check("no_restart", {63'h0, ks.busy}, 64'h0);

        // 4: reset mid-run at idx 9, then a clean restart
        push_enc();
        start_sched(KEY_MAIN);
        idle(9);
        check("pre_reset_idx", {60'h0, ks.round_idx}, 64'd9);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check("outstanding_after_reset", 64'(exp_q.size()), 64'd7);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("no_resume_after_reset", {63'h0, ks.key_valid}, 64'h0);
        push_enc();
        start_sched(KEY_MAIN);
        wait_done(40);
        idle(2);

`ifdef DES_KEY_DECRYPT_EN
        // 5: decrypt order K16..K1
        push_dec();
        ks.decrypt = 1'b1;
        start_sched(KEY_MAIN);
        ks.decrypt = 1'b0;
        wait_done(40);
        idle(2);
        push_enc();
        start_sched(KEY_MAIN);
        wait_done(40);
        idle(2);
`endif

        // 6: weak key gives all-zero subkeys and exactly one done pulse
        done_base = done_cnt;
        push_zero();
        start_sched(KEY_WEAK);
        wait_done(40);
        idle(4);
        check("weak_done_once", 64'(done_cnt - done_base), 64'd1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
